mult_fu: RTL and testbench

Pipelined RV32M multiply functional unit that produces results for the CDB's multiplier slot. Accepts one issued multiply per cycle from the reservation station and computes it over `STAGES` register stages. Presents the finished result as `mult_prepared` / `mult_packet`, and holds it under backpressure until the CDB signals `mult_avail`. This block is the sending side of the CDB's per-FU prepared/avail handshake, and is instantiated `NUM_FU_MULT` times.

---
 rtl/mult_fu_if.sv | 34 +++
 rtl/mult_fu.sv | 113 +++++++++++
 tb/tb_mult_fu.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_fu_if.sv
// Issue-side and CDB-side signals of one multiply functional unit.
// The master drives issue/squash/avail; the slave is the FU itself.
interface mult_fu_if #(
    parameter int ROB_CNT_WIDTH = 5,
    parameter int PRN_WIDTH     = 6
) ();
    typedef struct packed {
        logic [ROB_CNT_WIDTH-1:0] robn;
        logic [PRN_WIDTH-1:0]     dest_prn;
        logic [31:0]              result;
    } mult_packet_t;

    logic                     issue_valid;
    logic                     issue_ready;
    logic [31:0]              rs1_value;
    logic [31:0]              rs2_value;
    logic [1:0]               func;
    logic [ROB_CNT_WIDTH-1:0] robn;
    logic [PRN_WIDTH-1:0]     dest_prn;
    logic                     squash;
    logic                     mult_avail;
    logic                     mult_prepared;
    mult_packet_t             mult_packet;

    modport master (
        output issue_valid, rs1_value, rs2_value, func, robn, dest_prn, squash, mult_avail,
        input  issue_ready, mult_prepared, mult_packet
    );

    modport slave (
        input  issue_valid, rs1_value, rs2_value, func, robn, dest_prn, squash, mult_avail,
        output issue_ready, mult_prepared, mult_packet
    );
endinterface

// File: rtl/mult_fu.sv
// Pipelined RV32M multiplier: each stage folds one CH-bit chunk of the multiplier
// into a 64-bit partial sum; the last stage doubles as the CDB output register.
module mult_fu #(
    parameter int STAGES        = 4,
    parameter int ROB_CNT_WIDTH = 5,
    parameter int PRN_WIDTH     = 6
) (
    input  logic     clock,
    input  logic     reset,
    mult_fu_if.slave bus
);
    localparam int CH   = 64 / STAGES;
    localparam int LAST = STAGES - 1;

    logic [STAGES-1:0]        valid_q, valid_d;
    logic [ROB_CNT_WIDTH-1:0] robn_q   [STAGES];
    logic [ROB_CNT_WIDTH-1:0] robn_d   [STAGES];
    logic [PRN_WIDTH-1:0]     prn_q    [STAGES];
    logic [PRN_WIDTH-1:0]     prn_d    [STAGES];
    logic [1:0]               func_q   [STAGES];
    logic [1:0]               func_d   [STAGES];
    logic [63:0]              mcand_q  [STAGES];
    logic [63:0]              mcand_d  [STAGES];
    logic [63:0]              mplier_q [STAGES];
    logic [63:0]              mplier_d [STAGES];
    logic [63:0]              sum_q    [STAGES];
    logic [63:0]              sum_d    [STAGES];
    logic [63:0]              pp       [STAGES];

    logic [63:0] issue_mcand;
    logic [63:0] issue_mplier;
    logic [31:0] result;
    logic        advance;

    // MULHU is the only op with an unsigned rs1; func[1] marks an unsigned rs2.
    assign issue_mcand  = (bus.func == 2'b11) ? {32'b0, bus.rs1_value}
                                              : {{32{bus.rs1_value[31]}}, bus.rs1_value};
    assign issue_mplier = bus.func[1] ? {32'b0, bus.rs2_value}
                                      : {{32{bus.rs2_value[31]}}, bus.rs2_value};

    // Stage gi contributes mcand * chunk gi, aligned to its bit position.
    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_pp
            if (gi == 0) begin : g_first
                assign pp[gi] = issue_mcand * 64'(issue_mplier[CH-1:0]);
            end else begin : g_rest
                assign pp[gi] = (mcand_q[gi-1] * 64'(mplier_q[gi-1][gi*CH +: CH])) << (gi*CH);
            end
        end
    endgenerate

    // A single advance signal stalls the whole pipe; bubbles are never squeezed out.
    assign advance = bus.mult_avail | ~valid_q[LAST];

    always_comb begin
        valid_d  = valid_q;
        robn_d   = robn_q;
        prn_d    = prn_q;
        func_d   = func_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        sum_d    = sum_q;
        if (advance) begin
            valid_d[0]  = bus.issue_valid;
            robn_d[0]   = bus.robn;
            prn_d[0]    = bus.dest_prn;
            func_d[0]   = bus.func;
            mcand_d[0]  = issue_mcand;
            mplier_d[0] = issue_mplier;
            sum_d[0]    = pp[0];
            for (int i = 1; i < STAGES; i++) begin
                valid_d[i]  = valid_q[i-1];
                robn_d[i]   = robn_q[i-1];
                prn_d[i]    = prn_q[i-1];
                func_d[i]   = func_q[i-1];
                mcand_d[i]  = mcand_q[i-1];
                mplier_d[i] = mplier_q[i-1];
                sum_d[i]    = sum_q[i-1] + pp[i];
            end
        end
        if (bus.squash) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                robn_q[i]   <= '0;
                prn_q[i]    <= '0;
                func_q[i]   <= '0;
                mcand_q[i]  <= '0;
                mplier_q[i] <= '0;
                sum_q[i]    <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            robn_q   <= robn_d;
            prn_q    <= prn_d;
            func_q   <= func_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            sum_q    <= sum_d;
        end
    end

    assign result = (func_q[LAST] == 2'b00) ? sum_q[LAST][31:0] : sum_q[LAST][63:32];

    assign bus.issue_ready   = advance;
    assign bus.mult_prepared = valid_q[LAST];
    assign bus.mult_packet   = {robn_q[LAST], prn_q[LAST], result};
endmodule

// File: tb/tb_mult_fu.sv
// Scoreboard bench for mult_fu: stimulus pushes expected packets, a negedge
// monitor pops one per CDB transfer and compares packet and arrival cycle.
module tb_mult_fu;
    logic clock;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    mult_fu_if #(.ROB_CNT_WIDTH(5), .PRN_WIDTH(6)) bus ();

    mult_fu #(.STAGES(4), .ROB_CNT_WIDTH(5), .PRN_WIDTH(6)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [4:0]  robn;
        logic [5:0]  prn;
        logic [31:0] res;
        int          ec;
    } exp_t;
    exp_t exp_q[$];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: a transfer happens at the edge ending a cycle with prepared & avail.
    always @(negedge clock) begin
        if (!reset && bus.mult_prepared === 1'b1 && bus.mult_avail === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 64'(bus.mult_packet), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("packet", 64'(bus.mult_packet), 64'({e.robn, e.prn, e.res}));
                if (e.ec >= 0) check("latency", 64'(cyc), 64'(e.ec));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, input logic [5:0] p);
        bus.issue_valid = 1'b1;
        bus.func        = f;
        bus.rs1_value   = a;
        bus.rs2_value   = b;
        bus.robn        = r;
        bus.dest_prn    = p;
    endtask

    task automatic expect_res(input logic [4:0] r, input logic [5:0] p,
                              input logic [31:0] res, input int ec);
        exp_t e;
        e.robn = r; e.prn = p; e.res = res; e.ec = ec;
        exp_q.push_back(e);
    endtask

    task automatic drain(input int max);
        for (int i = 0; i < max && exp_q.size() != 0; i++) tick();
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // Directed vectors: func, rs1, rs2, hand-computed result.
    logic [1:0]  vf [10] = '{2'b11, 2'b01, 2'b01, 2'b10, 2'b00,
                             2'b00, 2'b11, 2'b01, 2'b10, 2'b00};
    logic [31:0] va [10] = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h00010000,
                             32'h0000FFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF};
    logic [31:0] vb [10] = '{32'h80000000, 32'h80000000, 32'h7FFFFFFF, 32'h80000000, 32'h00010000,
                             32'h0000FFFF, 32'h00000002, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] vr [10] = '{32'h40000000, 32'h40000000, 32'hC0000000, 32'hC0000000, 32'h00000000,
                             32'hFFFE0001, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 32'h00000001};

    initial begin
        int c0;
        logic [42:0] saved;
        reset           = 1'b0;
        bus.issue_valid = 1'b0;
        bus.func        = 2'b00;
        bus.rs1_value   = '0;
        bus.rs2_value   = '0;
        bus.robn        = '0;
        bus.dest_prn    = '0;
        bus.squash      = 1'b0;
        bus.mult_avail  = 1'b1;

        // Reset state, observed before any clock edge.
        #1 reset = 1'b1;
        #1;
        check("reset_prepared", 64'(bus.mult_prepared), 64'd0);
        check("reset_packet", 64'(bus.mult_packet), 64'd0);
        check("reset_ready", 64'(bus.issue_ready), 64'd1);
        tick(); tick();
        reset = 1'b0;
        tick();

        // Basic MUL: 3 * -4.
        c0 = cyc;
        drive(2'b00, 32'd3, 32'hFFFFFFFC, 5'd1, 6'd2);
        expect_res(5'd1, 6'd2, 32'hFFFFFFF4, c0 + 4);
        tick();
        bus.issue_valid = 1'b0;
        drain(12);

        // High-half variants back to back.
        c0 = cyc;
        drive(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 6'd4);
        expect_res(5'd3, 6'd4, 32'h00000000, c0 + 4);
        tick();
        drive(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 6'd5);
        expect_res(5'd4, 6'd5, 32'hFFFFFFFE, c0 + 5);
        tick();
        drive(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 6'd6);
        expect_res(5'd5, 6'd6, 32'hFFFFFFFF, c0 + 6);
        tick();
        bus.issue_valid = 1'b0;
        drain(12);

        // Table of directed vectors at full throughput.
        c0 = cyc;
        for (int i = 0; i < 10; i++) begin
            drive(vf[i], va[i], vb[i], 5'(i), 6'(i + 10));
            expect_res(5'(i), 6'(i + 10), vr[i], c0 + 4 + i);
            tick();
        end
        bus.issue_valid = 1'b0;
        drain(20);

        // Backpressure: four in flight, output held for three cycles.
        c0 = cyc;
        for (int k = 0; k < 4; k++) begin
            drive(2'b00, 32'(k + 2), 32'd5, 5'(20 + k), 6'(30 + k));
            expect_res(5'(20 + k), 6'(30 + k), 32'((k + 2) * 5), c0 + 7 + k);
            tick();
        end
        bus.issue_valid = 1'b0;
        bus.mult_avail  = 1'b0;
        #1;
        saved = bus.mult_packet;
        check("bp_first_packet", 64'(saved), 64'({5'd20, 6'd30, 32'd10}));
        for (int s = 0; s < 3; s++) begin
            check("bp_prepared", 64'(bus.mult_prepared), 64'd1);
            check("bp_ready", 64'(bus.issue_ready), 64'd0);
            check("bp_stable", 64'(bus.mult_packet), 64'(saved));
            tick();
        end
        bus.mult_avail = 1'b1;
        drain(12);

        // Stall with empty output: the pipe still fills.
        bus.mult_avail = 1'b0;
        c0 = cyc;
        drive(2'b00, 32'd7, 32'd6, 5'd3, 6'd4);
        tick();
        bus.issue_valid = 1'b0;
        for (int k = 1; k < 4; k++) begin
            check("fill_prepared", 64'(bus.mult_prepared), 64'd0);
            check("fill_ready", 64'(bus.issue_ready), 64'd1);
            tick();
        end
        check("fill_cycle", 64'(cyc), 64'(c0 + 4));
        check("fill_arrived", 64'(bus.mult_prepared), 64'd1);
        check("fill_ready_drop", 64'(bus.issue_ready), 64'd0);
        check("fill_packet", 64'(bus.mult_packet), 64'({5'd3, 6'd4, 32'h2A}));
        expect_res(5'd3, 6'd4, 32'h2A, -1);
        bus.mult_avail = 1'b1;
        drain(12);

        // Squash with an issue in the same cycle, then a fresh issue.
        c0 = cyc;
        drive(2'b00, 32'd1, 32'd1, 5'd11, 6'd11);
        tick();
        drive(2'b00, 32'd2, 32'd2, 5'd12, 6'd12);
        tick();
        drive(2'b00, 32'd3, 32'd3, 5'd13, 6'd13);
        bus.squash = 1'b1;
        tick();
        bus.squash = 1'b0;
        drive(2'b00, 32'd9, 32'd9, 5'd7, 6'd8);
        expect_res(5'd7, 6'd8, 32'h51, c0 + 7);
        check("squash_prepared", 64'(bus.mult_prepared), 64'd0);
        tick();
        bus.issue_valid = 1'b0;
        for (int k = 4; k < 7; k++) begin
            check("squash_prepared", 64'(bus.mult_prepared), 64'd0);
            tick();
        end
        drain(12);

        // Asynchronous reset with the output valid and ops in flight.
        bus.mult_avail = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(2'b00, 32'(k + 1), 32'd3, 5'(15 + k), 6'(15 + k));
            tick();
        end
        bus.issue_valid = 1'b0;
        tick();
        check("pre_reset_prepared", 64'(bus.mult_prepared), 64'd1);
        #1 reset = 1'b1;
        #1;
        check("async_prepared", 64'(bus.mult_prepared), 64'd0);
        check("async_packet", 64'(bus.mult_packet), 64'd0);
        check("async_ready", 64'(bus.issue_ready), 64'd1);
        #1 reset = 1'b0;
        bus.mult_avail = 1'b1;
        tick();
        c0 = cyc;
        drive(2'b01, 32'h80000000, 32'h7FFFFFFF, 5'd9, 6'd10);
        expect_res(5'd9, 6'd10, 32'hC0000000, c0 + 4);
        tick();
        bus.issue_valid = 1'b0;
        drain(12);

        tick(); tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
